// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencer for an iterative shift-add multiplier in the EX stage.
// Captures the operands on issue, accumulates BITS_PER_CYCLE multiplier bits per
// cycle for WIDTH/BITS_PER_CYCLE cycles, stalls the front of the pipeline while
// busy, then presents the low WIDTH bits of the product for one writeback cycle.
module mul_seq_ctrl #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] rd_value_i,
   input  logic [WIDTH-1:0] src_i,
   input  logic [3:0]       rd_addr_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             wb_en_o,
   output logic [3:0]       rd_addr_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_flag_o,
   output logic             neg_flag_o
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         rd_q;

   logic               accept;
   logic [WIDTH-1:0]   step_pp;

   // A new operation is taken whenever the sequencer is not running and no flush
   // is cancelling the issuing instruction.
   assign accept = (state != RUN) && start_i && !flush_i;

   // Partial product for the multiplier bits consumed this step, kept to WIDTH bits
   // since only the low half of the full product is ever returned.
   always_comb begin
      // NOTE: give every always_comb target a default first so no path can infer a latch.
      step_pp = '0;
      step_pp = mcand * WIDTH'(mplier[BITS_PER_CYCLE-1:0]);
   end

   // Control state machine and shift-add datapath.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // samples the pre-edge values of the others regardless of statement order.
      if (!rst) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         rd_q   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  mcand  <= rd_value_i;
                  mplier <= src_i;
                  acc    <= '0;
                  cnt    <= CNT_W'(N);
                  rd_q   <= rd_addr_i;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               if (flush_i) begin
                  // Abort: result and destination stay as they were, no writeback.
                  state <= IDLE;
               end else begin
                  acc    <= acc + step_pp;
                  mcand  <= mcand << BITS_PER_CYCLE;
                  mplier <= mplier >> BITS_PER_CYCLE;
                  cnt    <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state <= DONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stall covers the issue cycle as well as every RUN cycle, so the pipeline only
   // advances again in the DONE cycle when the result is written back.
   assign stall_o     = accept || (state == RUN);
   assign busy_o      = (state == RUN);
   assign done_o      = (state == DONE);
   assign wb_en_o     = (state == DONE);
   assign result_o    = acc;
   assign rd_addr_o   = rd_q;
   assign zero_flag_o = (acc == '0);
   assign neg_flag_o  = acc[WIDTH-1];

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencer for an iterative shift-add multiplier in the EX stage. It drives the multiply path that feeds the `ctrl_mul_i` / `result_mul_i` inputs of the EX result register. On a multiply issue it captures the operands and runs `WIDTH/BITS_PER_CYCLE` accumulate steps. It holds the front of the pipeline with `stall_o` while busy, then presents the low `WIDTH` bits of the product with writeback control and flags for exactly one cycle.

## Interface
- `WIDTH`, 32, operand and result width.
- `BITS_PER_CYCLE`, 1, multiplier bits consumed per step. Legal values: 1, 2, 4. Must divide `WIDTH`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  multiply issue (`ctrl_mul` qualified by a valid instruction).
- `flush_i`  in  1  branch-taken flush; aborts any operation in flight.
- `rd_value_i`  in  WIDTH  multiplicand (rd operand).
- `src_i`  in  WIDTH  multiplier (already muxed between imm and rs).
- `rd_addr_i`  in  4  destination register.
- `stall_o`  out  1  hold upstream stages.
- `busy_o`  out  1  state is RUN.
- `done_o`  out  1  result valid pulse.
- `wb_en_o`  out  1  writeback enable; equals `done_o`.
- `rd_addr_o`  out  4  captured destination.
- `result_o`  out  WIDTH  product, low `WIDTH` bits.
- `zero_flag_o`, `neg_flag_o`  out  1  each; product is zero, product MSB.

## Operation
- The state machine has three states: IDLE, RUN, DONE. Reset enters IDLE.
- Registers:
  - `mcand`, WIDTH bits, shifts left.
  - `mplier`, WIDTH bits, shifts right.
  - `acc`, WIDTH bits.
  - `cnt`, log2(N)+1 bits, where N = `WIDTH/BITS_PER_CYCLE`.
  - `rd_q`, 4 bits.
- IDLE or DONE with `start_i=1` and `flush_i=0`:
  - `mcand` <= `rd_value_i`, `mplier` <= `src_i`, `acc` <= 0, `cnt` <= N, `rd_q` <= `rd_addr_i`.
  - Next state is RUN.
- RUN, each cycle:
  - `acc` <= `acc` + (`mcand` * `mplier[BITS_PER_CYCLE-1:0]`), truncated to WIDTH.
  - `mcand` <= `mcand` << `BITS_PER_CYCLE`.
  - `mplier` <= `mplier` >> `BITS_PER_CYCLE`.
  - `cnt` <= `cnt` - 1.
  - When `cnt`==1, next state is DONE.
- DONE: lasts one cycle. Next state is IDLE, or RUN if a new start is accepted.
- `flush_i=1` in RUN forces IDLE. No DONE is produced for the aborted operation; `acc` and `rd_q` are left as they are.
- `flush_i=1` together with `start_i` suppresses the start.
- `start_i` seen while in RUN is ignored. Upstream is already stalled, so it holds the instruction.
- Arithmetic is unsigned. The low WIDTH bits of a two's-complement product match the unsigned result, so signed operands need no special handling. Overflow is not detected.

## Timing
- Reset values: state IDLE, all registers 0.
  - `stall_o`, `busy_o`, `done_o`, `wb_en_o` = 0.
  - `result_o` = 0, `rd_addr_o` = 0.
  - `zero_flag_o` = 1, since the result is 0.
- Reset asserted in the middle of an operation drops to IDLE immediately. No `done_o` is produced.
- Start accepted at edge E0, then RUN during cycles 1..N, then DONE in cycle N+1. Latency from issue to `done_o` is N+1 cycles: 33 with default parameters, 9 with `BITS_PER_CYCLE`=4.
- `stall_o` is combinational:
  - high for (IDLE or DONE) and `start_i` and not `flush_i`;
  - high in every RUN cycle;
  - low otherwise.
  - Consequently `stall_o` is low in a DONE cycle with no new start, so the pipeline advances exactly when the result is written back.
- `result_o` = `acc`, `rd_addr_o` = `rd_q`. Both are registered and held stable from DONE until the next accepted start. The flags are decoded from `result_o`.
- `done_o` = `wb_en_o` = (state==DONE). It is a single-cycle pulse, never asserted on two consecutive cycles.
- Back-to-back issue: a start accepted in DONE still leaves `done_o` high in that cycle for the old result. The new operation starts RUN on the next cycle.

## Test plan
- 3 × 5, rd=4 -> `done_o` exactly 33 cycles after the start edge. `result_o`=0x0000000F, `rd_addr_o`=4, `wb_en_o`=1 for one cycle, `zero_flag_o`=0, `neg_flag_o`=0. `stall_o` high for 33 consecutive cycles (start cycle plus 32 RUN cycles), then low in DONE.
- 0xFFFFFFFF × 0xFFFFFFFF -> `result_o`=0x00000001. Then 0xFFFFFFFF × 2 -> `result_o`=0xFFFFFFFE with `neg_flag_o`=1.
- 0x00010000 × 0x00010000 -> `result_o`=0, `zero_flag_o`=1, `done_o`=1.
- Start, then `flush_i` on the 5th RUN cycle -> state IDLE next cycle, `stall_o`=0, no `done_o` within 40 cycles. A start with `flush_i`=1 in the same cycle -> ignored.
- `start_i` asserted in the DONE cycle (7×6, then 9×9) -> `done_o` with 42 in that cycle. The second result, 81, arrives N+1 cycles later. `done_o` is never high on two consecutive cycles.
- `rst` pulled low in the middle of RUN -> all outputs go to their reset values asynchronously, with no `done_o`. With `BITS_PER_CYCLE`=4, 0x1234 × 0x10 -> 0x12340 after 9 cycles.
